// File: rtl/status_uart_tx.sv
// rtl/status_uart_tx.sv - 8N1 UART transmitter for 5-byte game status packets
//
// Watches the game controller's state, mode and both scores. Whenever the
// registered sample differs from the last transmitted values, or a resend has
// been requested, it sends the packet 'S', {mode,state}, score1, score2, xor.
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset
//   state   game state code (3 bits)
//   mode    0 = single player, 1 = two player
//   score1  player-1 score
//   score2  player-2 score
//   resend  single-cycle request to retransmit the current status
//   data_t  UART serial output, idle high
//   busy    high while a packet is on the line

module status_uart_tx #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic       mode,
    input  logic [7:0] score1,
    input  logic [7:0] score2,
    input  logic       resend,
    output logic       data_t,
    output logic       busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
    localparam logic [7:0]  SYNC     = 8'h53;

    // Sample layout: {state[2:0], mode, score1[7:0], score2[7:0]}
    logic [19:0] sample;
    logic [19:0] shadow;
    logic [19:0] snap;
    logic        pending;
    logic [1:0]  fsm;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [2:0]  byte_idx;

    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [7:0]  cur_byte;
    logic        launch;
    logic        bit_end;
    logic        line_next;

    assign b1 = {4'b0000, snap[16], snap[19:17]};
    assign b2 = snap[15:8];
    assign b3 = snap[7:0];

    always_comb begin
        cur_byte = SYNC;
        case (byte_idx)
            3'd0:    cur_byte = SYNC;
            3'd1:    cur_byte = b1;
            3'd2:    cur_byte = b2;
            3'd3:    cur_byte = b3;
            default: cur_byte = SYNC ^ b1 ^ b2 ^ b3;
        endcase
    end

    assign launch  = (fsm == S_IDLE) && ((sample != shadow) || pending);
    assign bit_end = (baud_cnt == BAUD_MAX);

    always_comb begin
        line_next = 1'b1;
        case (fsm)
            S_START: line_next = 1'b0;
            S_DATA:  line_next = cur_byte[bit_idx];
            default: line_next = 1'b1;
        endcase
    end

    // data_t and busy are registered copies of the FSM's view, so the line
    // moves one clock after the FSM; every bit still lasts CLKS_PER_BIT clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample   <= '0;
            shadow   <= '0;
            snap     <= '0;
            pending  <= 1'b0;
            fsm      <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            data_t   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            sample <= {state, mode, score1, score2};
            data_t <= line_next;
            busy   <= (fsm != S_IDLE);

            // A resend coinciding with a launch is carried by that packet.
            if (launch)
                pending <= 1'b0;
            else if (resend)
                pending <= 1'b1;

            case (fsm)
                S_IDLE: begin
                    baud_cnt <= '0;
                    if (launch) begin
                        shadow   <= sample;
                        snap     <= sample;
                        byte_idx <= '0;
                        fsm      <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        fsm      <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7)
                            fsm <= S_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (byte_idx < 3'd4) begin
                            byte_idx <= byte_idx + 3'd1;
                            fsm      <= S_START;
                        end else begin
                            fsm <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/status_uart_tx.md
# status_uart_tx

Serial transmitter that reports game status back to the host over the player-1 UART link (8N1, LSB first), the outbound counterpart to the command receiver that feeds the game controller. It watches the controller's state, mode and both scores, and whenever any of them changes (or a resend is requested) it transmits a fixed 5-byte status packet on `data_t`. It sits beside the game controller in the top level, clocked by the system clock, not the 60 Hz game tick.

## Interface
- `CLKS_PER_BIT`, default 10417, system clocks per UART bit (100 MHz / 9600 baud); legal range 2..65535.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `state`  in  3  game state code from the controller (set0..fail).
- `mode`  in  1  0 = single player, 1 = two player.
- `score1`  in  8  player-1 score.
- `score2`  in  8  player-2 score.
- `resend`  in  1  single-cycle request to transmit the current status even if unchanged.
- `data_t`  out  1  UART serial output; idle high.
- `busy`  out  1  high while a packet is on the line.

## Operation
- Input stage: `state`, `mode`, `score1`, `score2` are registered every clock into a sample register (20 bits). `resend` sets a sticky `pending` flag.
- Shadow register: holds the last transmitted values. Change = sample differs from shadow.
- Packet, in order: B0 = 0x53 ('S'); B1 = {4'b0000, mode, state}; B2 = score1; B3 = score2; B4 = B0^B1^B2^B3.
- Byte frame: start bit (0), data bits 0..7 LSB first, stop bit (1). Bytes are back-to-back, with no extra idle between them.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `data_t`=1. If change or `pending`, then copy sample into both shadow and a packet snapshot, clear `pending`, set byte index 0, and go to START.
  - START: `data_t`=0 for CLKS_PER_BIT clocks, then go to DATA with bit index 0.
  - DATA: `data_t` = current byte bit[idx] for CLKS_PER_BIT clocks each. After bit 7, go to STOP.
  - STOP: `data_t`=1 for CLKS_PER_BIT clocks. Then, if byte index < 4, increment it and go to START; otherwise go to IDLE.
- All five bytes come from the snapshot taken at IDLE exit. Input changes during a packet do not alter it.
- Changes during a packet: the shadow is not updated. When the FSM returns to IDLE, the sample is compared against the shadow again. Any net change, or a `resend` that arrived mid-packet, starts exactly one new packet carrying the latest values. Intermediate values are dropped.
- A change that reverts before the FSM reaches IDLE produces no packet.
- `resend` asserted in the same cycle that IDLE launches a packet is absorbed by that packet (`pending` is cleared).
- Reset, also when asserted mid-packet: FSM returns to IDLE, `data_t`=1, `busy`=0, `pending`=0, sample/shadow/snapshot = 0, all counters = 0. Any partial frame is abandoned.
- Reset values therefore match state=0, mode=0, scores=0, so no packet follows reset unless the inputs are non-zero.

## Timing
- Baud counter: 16 bits, counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary. Every bit lasts exactly CLKS_PER_BIT clocks.
- Latency: input changes at edge E → sample updated at E → IDLE decision at E+1 → `data_t` falls and `busy` rises at E+2 (registered outputs).
- `resend` high at edge E → `pending` set at E → start bit at E+2.
- Packet length: 50 × CLKS_PER_BIT clocks from the start-bit edge to the end of the final stop bit. `busy` is high for exactly this interval.
- Between packets: at least 1 clock in IDLE with `data_t`=1 before the next start bit.
- Score arithmetic: none. Values are sent raw. The checksum is an 8-bit XOR; there is no carry.

## Test plan
- Reset, then hold inputs at 0 with CLKS_PER_BIT=4 for 500 clocks → `data_t` stays 1 and `busy` stays 0. Assert `rst` mid-packet → `data_t`=1 and `busy`=0 immediately, and no further bits follow.
- With CLKS_PER_BIT=4, set state=3, mode=1, score1=0x05, score2=0x02 → bytes 0x53, 0x0B, 0x05, 0x02, 0x5F decoded. Start bit appears 2 clocks after the input edge. `busy` is high for exactly 200 clocks.
- Pulse `resend` with inputs unchanged → identical packet repeated. Pulse `resend` twice within one packet → exactly one extra packet.
- Mid-packet, step score1 through 6, 7, 8 → current packet unchanged. Exactly one follow-up packet with score1=0x08 and checksum 0x53^0x0B^0x08^0x02=0x52.
- Mid-packet, change score2 to 9, then back to its previous value before the packet ends → no follow-up packet.
- With CLKS_PER_BIT=2, score1=0xFF, score2=0x00, state=5, mode=0 → bytes 0x53, 0x05, 0xFF, 0x00, 0xA9. Each bit is exactly 2 clocks wide. There is at least 1 idle clock before any next start bit.
